// File: rtl/pc_redirect_if.sv
// Bundles the fetch-stage redirect request/response signals of pc_redirect_ctrl.
// The slave modport is the controller; the master modport is whoever drives the requests.
interface pc_redirect_if #(
    parameter int XLEN = 32
);
    logic            enable_design;
    logic [XLEN-1:0] initial_pc_i;
    logic            stage_IF_ready;

    logic            trap_req_i;
    logic [XLEN-1:0] trap_pc_i;
    logic            mispred_req_i;
    logic [XLEN-1:0] mispred_pc_i;
    logic            jump_req_i;
    logic [XLEN-1:0] jump_pc_i;
    logic            pred_req_i;
    logic [XLEN-1:0] pred_pc_i;

    logic            redirect_valid_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic [3:0]      grant_o;
    logic            flush_o;
    logic            drop_o;
    logic            fetch_en_o;
    logic [1:0]      state_o;

    modport master (
        output enable_design, initial_pc_i, stage_IF_ready,
        output trap_req_i, trap_pc_i, mispred_req_i, mispred_pc_i,
        output jump_req_i, jump_pc_i, pred_req_i, pred_pc_i,
        input  redirect_valid_o, redirect_pc_o, grant_o, flush_o,
        input  drop_o, fetch_en_o, state_o
    );

    modport slave (
        input  enable_design, initial_pc_i, stage_IF_ready,
        input  trap_req_i, trap_pc_i, mispred_req_i, mispred_pc_i,
        input  jump_req_i, jump_pc_i, pred_req_i, pred_pc_i,
        output redirect_valid_o, redirect_pc_o, grant_o, flush_o,
        output drop_o, fetch_en_o, state_o
    );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Fetch-stage PC sequencing: boot delay, initial-PC load, then four-way redirect
// arbitration with a single pending slot that holds a redirect while IF is stalled.
module pc_redirect_ctrl #(
    parameter int XLEN       = 32,
    parameter int BOOT_DELAY = 4
) (
    input  logic            clk,
    input  logic            reset,
    pc_redirect_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BOOT = 2'd1,
        LOAD = 2'd2,
        RUN  = 2'd3
    } state_t;

    state_t          state;
    logic [7:0]      boot_cnt;

    logic            pend_v;
    logic [1:0]      pend_src;
    logic [XLEN-1:0] pend_pc;

    logic            redirect_valid_q;
    logic [XLEN-1:0] redirect_pc_q;
    logic [3:0]      grant_q;
    logic            flush_q;
    logic            drop_q;
    logic            fetch_en_q;

    logic [3:0]      req_v;
    logic [XLEN-1:0] req_pc [4];

    logic            cand_v;
    logic [1:0]      cand_src;
    logic [XLEN-1:0] cand_pc;
    logic            cand_from_pend;
    logic [3:0]      win_mask;
    logic            drop_next;

    // Index 0 is the highest priority (trap), index 3 the lowest (predicted branch).
    assign req_v     = {bus.pred_req_i, bus.jump_req_i, bus.mispred_req_i, bus.trap_req_i};
    assign req_pc[0] = bus.trap_pc_i;
    assign req_pc[1] = bus.mispred_pc_i;
    assign req_pc[2] = bus.jump_pc_i;
    assign req_pc[3] = bus.pred_pc_i;

    // Walk from lowest to highest priority so later hits override; at equal
    // priority the incoming request is checked after the pending entry and wins.
    always_comb begin
        cand_v         = 1'b0;
        cand_src       = 2'd0;
        cand_pc        = '0;
        cand_from_pend = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (pend_v && (pend_src == 2'(i))) begin
                cand_v         = 1'b1;
                cand_src       = 2'(i);
                cand_pc        = pend_pc;
                cand_from_pend = 1'b1;
            end
            if (req_v[i]) begin
                cand_v         = 1'b1;
                cand_src       = 2'(i);
                cand_pc        = req_pc[i];
                cand_from_pend = 1'b0;
            end
        end
    end

    // Everything that was valid but did not win is lost: losing requests and a displaced pending entry.
    always_comb begin
        win_mask  = cand_from_pend ? 4'b0000 : (4'b0001 << cand_src);
        drop_next = (|(req_v & ~win_mask)) | (pend_v & ~cand_from_pend);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= IDLE;
            boot_cnt         <= 8'd0;
            pend_v           <= 1'b0;
            pend_src         <= 2'd0;
            pend_pc          <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            grant_q          <= 4'b0000;
            flush_q          <= 1'b0;
            drop_q           <= 1'b0;
            fetch_en_q       <= 1'b0;
        end else begin
            redirect_valid_q <= 1'b0;
            grant_q          <= 4'b0000;
            flush_q          <= 1'b0;
            drop_q           <= 1'b0;
            fetch_en_q       <= 1'b0;

            if (!bus.enable_design) begin
                state    <= IDLE;
                boot_cnt <= 8'd0;
                pend_v   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state    <= BOOT;
                        boot_cnt <= 8'(BOOT_DELAY - 1);
                    end
                    BOOT: begin
                        if (boot_cnt == 8'd0) begin
                            state <= LOAD;
                        end else begin
                            boot_cnt <= boot_cnt - 8'd1;
                        end
                    end
                    LOAD: begin
                        if (bus.stage_IF_ready) begin
                            redirect_valid_q <= 1'b1;
                            redirect_pc_q    <= bus.initial_pc_i;
                            flush_q          <= 1'b1;
                            state            <= RUN;
                        end
                    end
                    RUN: begin
                        drop_q     <= drop_next;
                        fetch_en_q <= ~cand_v;
                        if (cand_v) begin
                            if (bus.stage_IF_ready) begin
                                redirect_valid_q <= 1'b1;
                                redirect_pc_q    <= cand_pc;
                                grant_q          <= 4'b0001 << cand_src;
                                flush_q          <= (cand_src != 2'd3);
                                pend_v           <= 1'b0;
                            end else begin
                                pend_v   <= 1'b1;
                                pend_src <= cand_src;
                                pend_pc  <= cand_pc;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.redirect_valid_o = redirect_valid_q;
    assign bus.redirect_pc_o    = redirect_pc_q;
    assign bus.grant_o          = grant_q;
    assign bus.flush_o          = flush_q;
    assign bus.drop_o           = drop_q;
    assign bus.fetch_en_o       = fetch_en_q;
    assign bus.state_o          = state;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: directed scenarios followed by random
// traffic, all compared every cycle against a behavioural model of the controller.
module tb_pc_redirect_ctrl;

    localparam int XLEN       = 32;
    localparam int BOOT_DELAY = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_redirect_if #(.XLEN(XLEN)) bus ();

    pc_redirect_ctrl #(.XLEN(XLEN), .BOOT_DELAY(BOOT_DELAY)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0..3, boot progress as cycles spent in BOOT, one pending slot.
    int              m_phase;
    int              m_boot_cycles;
    bit              m_pend_v;
    int              m_pend_prio;
    logic [XLEN-1:0] m_pend_pc;

    logic            exp_valid;
    logic [XLEN-1:0] exp_pc;
    logic [3:0]      exp_grant;
    logic            exp_flush;
    logic            exp_drop;
    logic            exp_fetch;
    logic [1:0]      exp_state;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [3:0]      req;
        logic [XLEN-1:0] pcs [4];
        int              count;
        int              best;
        logic [XLEN-1:0] best_pc;
        req     = {bus.pred_req_i, bus.jump_req_i, bus.mispred_req_i, bus.trap_req_i};
        pcs[0]  = bus.trap_pc_i;
        pcs[1]  = bus.mispred_pc_i;
        pcs[2]  = bus.jump_pc_i;
        pcs[3]  = bus.pred_pc_i;
        exp_valid = 1'b0;
        exp_grant = 4'b0000;
        exp_flush = 1'b0;
        exp_drop  = 1'b0;
        exp_fetch = 1'b0;
        if (!reset) begin
            m_phase = 0; m_boot_cycles = 0; m_pend_v = 0;
        end else if (!bus.enable_design) begin
            m_phase = 0; m_pend_v = 0;
        end else begin
            case (m_phase)
                0: begin m_phase = 1; m_boot_cycles = 1; end
                1: begin
                    if (m_boot_cycles == BOOT_DELAY) m_phase = 2;
                    else m_boot_cycles++;
                end
                2: begin
                    if (bus.stage_IF_ready) begin
                        exp_valid = 1'b1; exp_pc = bus.initial_pc_i; exp_flush = 1'b1;
                        m_phase = 3;
                    end
                end
                default: begin
                    count = m_pend_v ? 1 : 0;
                    for (int p = 0; p < 4; p++) if (req[p]) count++;
                    best = -1;
                    best_pc = '0;
                    for (int p = 0; p < 4 && best < 0; p++) begin
                        if (req[p]) begin best = p; best_pc = pcs[p]; end
                        else if (m_pend_v && m_pend_prio == p) begin best = p; best_pc = m_pend_pc; end
                    end
                    exp_drop  = (count > 1);
                    exp_fetch = (count == 0);
                    if (best >= 0) begin
                        if (bus.stage_IF_ready) begin
                            exp_valid = 1'b1;
                            exp_pc    = best_pc;
                            exp_grant = 4'(1 << best);
                            exp_flush = (best != 3);
                            m_pend_v  = 0;
                        end else begin
                            m_pend_v = 1; m_pend_prio = best; m_pend_pc = best_pc;
                        end
                    end
                end
            endcase
        end
        exp_state = 2'(m_phase);
    endtask

    task automatic check_output();
        check("state",    XLEN'(bus.state_o),          XLEN'(exp_state));
        check("valid",    XLEN'(bus.redirect_valid_o), XLEN'(exp_valid));
        check("grant",    XLEN'(bus.grant_o),          XLEN'(exp_grant));
        check("flush",    XLEN'(bus.flush_o),          XLEN'(exp_flush));
        check("drop",     XLEN'(bus.drop_o),           XLEN'(exp_drop));
        check("fetch_en", XLEN'(bus.fetch_en_o),       XLEN'(exp_fetch));
        if (exp_valid) check("pc", bus.redirect_pc_o, exp_pc);
    endtask

    task automatic apply_stimulus(input logic [3:0] req, input logic [XLEN-1:0] pc0,
                                  input logic [XLEN-1:0] pc1, input logic [XLEN-1:0] pc2,
                                  input logic [XLEN-1:0] pc3, input logic rdy);
        bus.trap_req_i    = req[0]; bus.trap_pc_i    = pc0;
        bus.mispred_req_i = req[1]; bus.mispred_pc_i = pc1;
        bus.jump_req_i    = req[2]; bus.jump_pc_i    = pc2;
        bus.pred_req_i    = req[3]; bus.pred_pc_i    = pc3;
        bus.stage_IF_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_output();
    endtask

    task automatic boot_to_run();
        bus.enable_design = 1'b1;
        apply_stimulus(4'b0000, '0, '0, '0, '0, 1'b1);
        repeat (BOOT_DELAY + 3) tick();
        check("boot_fetch_en", XLEN'(bus.fetch_en_o), XLEN'(1'b1));
    endtask

    initial begin
        logic [1:0] boot_seq [5];
        boot_seq = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
        m_phase = 0; m_boot_cycles = 0; m_pend_v = 0; m_pend_prio = 0; m_pend_pc = '0;
        exp_pc = '0;

        reset = 1'b0;
        bus.enable_design = 1'b0;
        bus.initial_pc_i  = 32'h0000_1000;
        apply_stimulus(4'b0000, '0, '0, '0, '0, 1'b1);
        repeat (2) tick();
        check("reset_pc", bus.redirect_pc_o, '0);

        // Boot sequence with explicit state trace
        reset = 1'b1;
        repeat (2) tick();
        bus.enable_design = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("boot_seq", XLEN'(bus.state_o), XLEN'(boot_seq[k]));
        end
        tick();
        check("boot_valid", XLEN'(bus.redirect_valid_o), XLEN'(1'b1));
        check("boot_pc",    bus.redirect_pc_o, 32'h0000_1000);
        check("boot_grant", XLEN'(bus.grant_o), '0);
        check("boot_flush", XLEN'(bus.flush_o), XLEN'(1'b1));
        tick();
        check("boot_fetch", XLEN'(bus.fetch_en_o), XLEN'(1'b1));

        // Priority: trap beats mispredict and predicted branch
        apply_stimulus(4'b1011, 32'h80, 32'h200, '0, 32'h300, 1'b1);
        tick();
        check("prio_pc",    bus.redirect_pc_o, 32'h80);
        check("prio_grant", XLEN'(bus.grant_o), XLEN'(4'b0001));
        check("prio_drop",  XLEN'(bus.drop_o), XLEN'(1'b1));
        apply_stimulus(4'b0000, '0, '0, '0, '0, 1'b1);
        tick();

        // Stall and upgrade: pending pred displaced by jump
        apply_stimulus(4'b1000, '0, '0, '0, 32'h300, 1'b0);
        tick();
        apply_stimulus(4'b0100, '0, '0, 32'h400, '0, 1'b0);
        tick();
        check("upg_drop", XLEN'(bus.drop_o), XLEN'(1'b1));
        apply_stimulus(4'b0000, '0, '0, '0, '0, 1'b0);
        tick();
        check("upg_no_redirect", XLEN'(bus.redirect_valid_o), '0);
        apply_stimulus(4'b0000, '0, '0, '0, '0, 1'b1);
        tick();
        check("upg_pc",    bus.redirect_pc_o, 32'h400);
        check("upg_grant", XLEN'(bus.grant_o), XLEN'(4'b0100));
        tick();
        check("upg_single", XLEN'(bus.redirect_valid_o), '0);

        // Pred-only redirect does not flush
        apply_stimulus(4'b1000, '0, '0, '0, 32'h500, 1'b1);
        tick();
        check("pred_flush", XLEN'(bus.flush_o), '0);
        check("pred_grant", XLEN'(bus.grant_o), XLEN'(4'b1000));
        apply_stimulus(4'b0000, '0, '0, '0, '0, 1'b1);
        tick();

        // Disable with a stalled mispredict pending
        apply_stimulus(4'b0010, '0, 32'h600, '0, '0, 1'b0);
        tick();
        bus.enable_design = 1'b0;
        apply_stimulus(4'b0000, '0, '0, '0, '0, 1'b1);
        tick();
        check("dis_state", XLEN'(bus.state_o), '0);
        repeat (3) tick();
        boot_to_run();

        // Reset with a stalled jump pending
        apply_stimulus(4'b0100, '0, '0, 32'h700, '0, 1'b0);
        tick();
        reset = 1'b0;
        apply_stimulus(4'b0000, '0, '0, '0, '0, 1'b1);
        tick();
        check("rst_pc", bus.redirect_pc_o, '0);
        reset = 1'b1;
        boot_to_run();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            reset             = ($urandom_range(0, 149) != 0);
            bus.enable_design = ($urandom_range(0, 59) != 0);
            bus.initial_pc_i  = $urandom;
            apply_stimulus(4'($urandom & $urandom), $urandom, $urandom, $urandom, $urandom,
                           ($urandom_range(0, 3) != 0));
            tick();
        end

        $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Sequencing and arbitration controller for the fetch-stage PC unit. Brings the PC up after `enable_design` with a boot delay and an initial-PC load. Arbitrates four redirect requesters (trap, mispredict, jump, predicted-taken branch) into one registered redirect per cycle. Holds a redirect pending while the IF stage is stalled.

## Interface
Parameters:
- `XLEN`, 32, PC width.
- `BOOT_DELAY`, 4, cycles spent in BOOT before the initial-PC load; legal range 1–255.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `enable_design`  in  1  core enable; low forces IDLE.
- `initial_pc_i`  in  XLEN  boot PC, sampled in LOAD.
- `stage_IF_ready`  in  1  IF stage can accept a redirect this cycle.
- `trap_req_i` / `trap_pc_i`  in  1 / XLEN  trap redirect, priority 0 (highest).
- `mispred_req_i` / `mispred_pc_i`  in  1 / XLEN  resolved-branch mispredict, priority 1.
- `jump_req_i` / `jump_pc_i`  in  1 / XLEN  decode-stage jump, priority 2.
- `pred_req_i` / `pred_pc_i`  in  1 / XLEN  predicted-taken branch, priority 3 (lowest).
- `redirect_valid_o`  out  1  one-cycle pulse: PC unit loads `redirect_pc_o`.
- `redirect_pc_o`  out  XLEN  redirect target.
- `grant_o`  out  4  one-hot source of current redirect, bit0 = trap … bit3 = pred; 0 for the boot load.
- `flush_o`  out  1  kill younger stages; high with any redirect except pred-sourced.
- `drop_o`  out  1  pulse: an incoming request lost arbitration and was discarded.
- `fetch_en_o`  out  1  PC may advance sequentially; high only in RUN with no pending redirect.
- `state_o`  out  2  IDLE=0, BOOT=1, LOAD=2, RUN=3.

## Operation
- State machine:
  - IDLE: wait for `enable_design`=1, then go to BOOT with the counter set to BOOT_DELAY-1.
  - BOOT: decrement the counter; at 0 go to LOAD.
  - LOAD: if `stage_IF_ready`, issue redirect to `initial_pc_i` (`grant_o`=0, `flush_o`=1) and go to RUN; else stay.
  - RUN: arbitrate.
- `enable_design`=0 in any state: next state IDLE, pending cleared, no redirect issued that cycle.
- Requests outside RUN are ignored; `drop_o` stays 0.
- Pending register holds `pend_v`, `pend_src`, `pend_pc`.
- RUN candidate selection: the highest-priority valid among the incoming requests and the pending entry.
  - An incoming request at priority equal to the pending entry replaces it (newer target wins).
  - All non-selected valid incoming requests set `drop_o`=1 next cycle.
  - A replaced pending entry also sets `drop_o`.
- If `stage_IF_ready`=1: register the candidate onto the redirect outputs, clear `pend_v`.
- If `stage_IF_ready`=0: store the candidate into pending; no redirect.
- `fetch_en_o` = (state==RUN) & ~`pend_v` & ~candidate-valid-this-cycle, registered.
- Widths: all PCs pass through unmodified at XLEN; no arithmetic on targets.

## Timing
- All outputs are registered.
- Reset values: `redirect_valid_o`=0, `redirect_pc_o`=0, `grant_o`=0, `flush_o`=0, `drop_o`=0, `fetch_en_o`=0, `state_o`=IDLE, `pend_v`=0, counter=0.
- Request-to-redirect latency: 1 cycle. A request sampled at edge t with `stage_IF_ready`=1 gives `redirect_valid_o`=1 during cycle t+1.
- Stalled request: redirect one cycle after the first edge where `stage_IF_ready`=1.
- `redirect_valid_o` is never high two cycles running from the same pending entry.
- Boot: from `enable_design` rising at edge e (state IDLE), LOAD is entered at edge e+BOOT_DELAY. The boot redirect pulses at e+BOOT_DELAY+1 if IF is ready.
- Reset low at any edge overrides everything: pending is lost, outputs return to reset values next cycle.
- `drop_o` and `redirect_valid_o` may assert in the same cycle.

## Test plan
- Boot: BOOT_DELAY=4, `initial_pc_i`=0x0000_1000, IF ready, enable at edge 10.
  - Required: `state_o` sequence 1,1,1,1,2.
  - Required: `redirect_valid_o`=1 with pc 0x1000, `grant_o`=0, `flush_o`=1 at cycle 15; `fetch_en_o`=1 from cycle 16.
- Priority: in RUN, assert trap(0x80), mispred(0x200), pred(0x300) in the same cycle, IF ready.
  - Required next cycle: pc=0x80, `grant_o`=0001, `flush_o`=1, `drop_o`=1.
- Stall and upgrade:
  - IF not ready; pred(0x300) at cycle N, jump(0x400) at N+1; IF ready at N+3.
  - Required: single redirect at N+4 with pc=0x400, `grant_o`=0100, `flush_o`=1; `drop_o` pulse at N+2.
- Pred-only redirect: pred(0x500), IF ready.
  - Required next cycle: `redirect_valid_o`=1, `flush_o`=0, `grant_o`=1000.
- Disable mid-run: pending mispred with IF stalled, `enable_design`=0.
  - Required: `state_o`=IDLE next cycle, no redirect ever issued for it, `fetch_en_o`=0.
- Reset mid-pending: pending jump, `reset`=0 one cycle.
  - Required: all outputs at reset values next cycle; re-enable replays the full boot sequence.
